// File: rtl/region_addr_gen.sv
// Burst address generator: turns {region, offset, len} commands into a stream of 16-bit addresses inside that region.
// Optional macro REGION_ADDR_WRAP_EN: offsets wrap 12'hFFF -> 12'h000 instead of truncating the burst with an err pulse.
module region_addr_gen #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_region,
  input  logic [11:0]      cmd_offset,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [15:0]      addr,
  output logic             addr_last,
  output logic             err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // the producer holds valid and its payload stable until that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_ERR   = 2'd2
  } state_e;

`ifdef REGION_ADDR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [3:0]       nibble_q, nibble_d;
  logic [11:0]      offset_q, offset_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             addr_valid_q, addr_last_q, err_q, busy_q;
  logic             last_d;
  logic             map_ok;
  logic [3:0]       map_nib;

  always_comb begin
    map_ok  = 1'b1;
    map_nib = 4'h0;
    case (cmd_region)
      3'd0, 3'd1, 3'd2, 3'd3: map_nib = {1'b0, cmd_region};
      3'd7:                   map_nib = 4'hF;
      default:                map_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    nibble_d = nibble_q;
    offset_d = offset_q;
    remain_d = remain_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (map_ok) begin
            state_d  = S_BURST;
            nibble_d = map_nib;
            offset_d = cmd_offset;
            remain_d = cmd_len;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_BURST: begin
        if (addr_ready) begin
          offset_d = offset_q + 12'd1;
          remain_d = remain_q - 1'b1;
          if (addr_last_q) begin
            // A last beat forced by the 12'hFFF boundary with beats still owed is a truncation.
            if (!WRAP_EN && offset_q == 12'hFFF && remain_q != '0) state_d = S_ERR;
            else                                                   state_d = S_IDLE;
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d = (remain_d == '0) || (!WRAP_EN && offset_d == 12'hFFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      nibble_q     <= 4'h0;
      offset_q     <= 12'h000;
      remain_q     <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      nibble_q     <= nibble_d;
      offset_q     <= offset_d;
      remain_q     <= remain_d;
      addr_valid_q <= (state_d == S_BURST);
      addr_last_q  <= (state_d == S_BURST) && last_d;
      err_q        <= (state_d == S_ERR);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign cmd_ready  = (state_q == S_IDLE) && !rst;
  assign addr_valid = addr_valid_q;
  assign addr       = {nibble_q, offset_q};
  assign addr_last  = addr_last_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_region_addr_gen.sv
// Directed bench for region_addr_gen; expected addresses are hand-computed and queued in exp_q.
// Build with REGION_ADDR_WRAP_EN defined to exercise the wrapping variant of the boundary case.
module tb_region_addr_gen;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_region;
  logic [11:0] cmd_offset;
  logic [11:0] cmd_len;
  logic        addr_valid;
  logic        addr_ready;
  logic [15:0] addr;
  logic        addr_last;
  logic        err;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          n_vec;
  int          n_err;

  region_addr_gen #(.LEN_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_region (cmd_region),
    .cmd_offset (cmd_offset),
    .cmd_len    (cmd_len),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_last  (addr_last),
    .err        (err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present a command for one cycle; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [2:0] region, input logic [11:0] offset, input logic [11:0] len);
    @(negedge clk);
    check("cmd_ready_idle", 16'(cmd_ready), 16'd1);
    cmd_region = region;
    cmd_offset = offset;
    cmd_len    = len;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // Drain exp_q, dropping addr_ready for stall_cycles cycles on beat index stall_beat.
  task automatic collect(input int stall_beat, input int stall_cycles);
    int beat;
    int left;
    int cyc;
    beat = 0;
    left = stall_cycles;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      addr_ready = !(beat == stall_beat && left > 0);
      if (!addr_ready) left--;
      check("addr_valid", 16'(addr_valid), 16'd1);
      if (addr_valid) begin
        check("addr", addr, exp_q[0]);
        check("addr_last", 16'(addr_last), 16'(exp_q.size() == 1));
        check("err_in_burst", 16'(err), 16'd0);
        check("cmd_ready_busy", 16'(cmd_ready), 16'd0);
        if (addr_ready) begin
          void'(exp_q.pop_front());
          beat++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    check("burst_done", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    addr_ready = 1'b1;
  endtask

  // Checks at the negedge right after the final handshake of a clean burst.
  task automatic check_clean_end();
    check("end_valid", 16'(addr_valid), 16'd0);
    check("end_cmd_ready", 16'(cmd_ready), 16'd1);
    check("end_err", 16'(err), 16'd0);
    check("end_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_region = 3'd0;
    cmd_offset = 12'h000;
    cmd_len    = 12'd0;
    addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_addr_valid", 16'(addr_valid), 16'd0);
    check("rst_addr", addr, 16'h0000);
    check("rst_addr_last", 16'(addr_last), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_cmd_ready_rel", 16'(cmd_ready), 16'd1);

    // Region 1 near the top of the window, no stall
    exp_q = '{16'h1FFC, 16'h1FFD, 16'h1FFE};
    send_cmd(3'd1, 12'hFFC, 12'd2);
    check("r1_busy", 16'(busy), 16'd1);
    collect(-1, 0);
    check_clean_end();

    // Region 7 single beat
    exp_q = '{16'hF800};
    send_cmd(3'd7, 12'h800, 12'd0);
    collect(-1, 0);
    check_clean_end();

    // Region 5 unmapped: err pulse, no address
    send_cmd(3'd5, 12'h123, 12'd4);
    check("unmap_err", 16'(err), 16'd1);
    check("unmap_busy", 16'(busy), 16'd1);
    check("unmap_valid", 16'(addr_valid), 16'd0);
    check("unmap_cmd_ready", 16'(cmd_ready), 16'd0);
    @(negedge clk);
    check("unmap_err_drop", 16'(err), 16'd0);
    check("unmap_valid2", 16'(addr_valid), 16'd0);
    check("unmap_busy2", 16'(busy), 16'd0);
    check("unmap_cmd_ready2", 16'(cmd_ready), 16'd1);

    // Region 2 with a 3-cycle stall on beat 2
    exp_q = '{16'h2500, 16'h2501, 16'h2502, 16'h2503};
    send_cmd(3'd2, 12'h500, 12'd3);
    collect(1, 3);
    check_clean_end();

    // Region 0 crossing the 12'hFFF boundary
`ifdef REGION_ADDR_WRAP_EN
    exp_q = '{16'h0FFE, 16'h0FFF, 16'h0000, 16'h0001};
    send_cmd(3'd0, 12'hFFE, 12'd3);
    collect(-1, 0);
    check_clean_end();
`else
    exp_q = '{16'h0FFE, 16'h0FFF};
    send_cmd(3'd0, 12'hFFE, 12'd3);
    collect(-1, 0);
    check("trunc_err", 16'(err), 16'd1);
    check("trunc_valid", 16'(addr_valid), 16'd0);
    check("trunc_cmd_ready", 16'(cmd_ready), 16'd0);
    @(negedge clk);
    check("trunc_err_drop", 16'(err), 16'd0);
    check("trunc_cmd_ready2", 16'(cmd_ready), 16'd1);
`endif

    // Region 3 burst interrupted by reset on beat 2, with a command offered during reset
    send_cmd(3'd3, 12'h100, 12'd5);
    check("r3_beat1", addr, 16'h3100);
    @(negedge clk);
    check("r3_beat2", addr, 16'h3101);
    check("r3_valid2", 16'(addr_valid), 16'd1);
    rst        = 1'b1;
    cmd_valid  = 1'b1;
    cmd_region = 3'd1;
    cmd_offset = 12'h010;
    cmd_len    = 12'd1;
    @(negedge clk);
    check("midrst_valid", 16'(addr_valid), 16'd0);
    check("midrst_addr", addr, 16'h0000);
    check("midrst_last", 16'(addr_last), 16'd0);
    check("midrst_err", 16'(err), 16'd0);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_cmd_ready", 16'(cmd_ready), 16'd0);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("postrst_not_accepted", 16'(busy), 16'd0);
    check("postrst_valid", 16'(addr_valid), 16'd0);
    exp_q = '{16'h1010, 16'h1011};
    send_cmd(3'd1, 12'h010, 12'd1);
    collect(-1, 0);
    check_clean_end();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/region_addr_gen.md
# region_addr_gen

Burst address generator: the encoding direction of the 16-bit memory-map region decoder. It accepts a command of region code, 12-bit start offset and beat count, then emits a valid/ready stream of 16-bit addresses, all inside that region. It sits between DMA/test-stimulus engines and the bus, so every address it issues decodes back to the commanded region.

## Interface
- LEN_W, 12: width of cmd_len; beats per burst = cmd_len + 1 (1..2^LEN_W).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_region  in  3  region code: 0 Boot ROM, 1 RAM, 2 Peripherals, 3 External, 7 Flash; 4–6 unmapped.
- cmd_offset  in  12  start offset within region.
- cmd_len  in  LEN_W  beats minus one.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  downstream accepts addr.
- addr  out  16  {region nibble, offset}.
- addr_last  out  1  final beat of burst.
- err  out  1  one-cycle pulse: unmapped region or truncated burst.
- busy  out  1  state != IDLE.

## Operation
- Region nibble map: 0→4'h0, 1→4'h1, 2→4'h2, 3→4'h3, 7→4'hF. Codes 4, 5, 6 are unmapped.
- States: IDLE, BURST, ERR.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready:
  - Mapped region: latch nibble, offset and remaining = cmd_len, then go to BURST.
  - Unmapped region: go to ERR. No address is emitted.
- BURST: addr_valid = 1. addr = {nibble, offset_q}. addr_last = (remaining == 0).
  - On addr_valid && addr_ready: offset_q += 1 (12-bit), remaining -= 1.
  - If that beat had addr_last, go to IDLE.
- ERR: err = 1 for exactly one cycle, then IDLE.
- Offset arithmetic is 12-bit only. The nibble never changes within a burst.
- Boundary offset 12'hFFF with beats remaining: behaviour is set by the macro (see Configuration).
- cmd_valid is ignored outside IDLE. Commands do not queue.
- cmd_len = 0 gives a single-beat burst, with addr_last set on the first beat.

## Timing
- All outputs registered except cmd_ready = (state == IDLE) && !rst.
- Reset values: addr_valid 0, addr 16'h0000, addr_last 0, err 0, busy 0, state IDLE.
- First address appears the cycle after command acceptance (latency 1).
- Throughput is one address per cycle while addr_ready is held high.
- Stall: while addr_valid && !addr_ready, addr and addr_last are held stable.
- After the last-beat handshake, addr_valid drops next cycle and cmd_ready is 1 that same cycle.
  - Minimum gap between bursts: 1 idle cycle.
- Unmapped command: err is high in the cycle after acceptance; cmd_ready returns the cycle after that.
- rst mid-burst: the next edge forces the reset values and drops the burst. No err pulse.
- rst and cmd_valid in the same cycle: reset wins and the command is not accepted.

## Configuration
- REGION_ADDR_WRAP_EN defined:
  - Offset wraps 12'hFFF → 12'h000 within the same region.
  - The burst continues for the full beat count, with no err.
- Not defined:
  - The beat at offset 12'hFFF is forced to addr_last = 1 and the burst ends there (truncated).
  - err pulses one cycle, the cycle after that beat's handshake.
  - Bursts that do not reach 12'hFFF behave identically in both builds.

## Test plan
- Region 1, offset 12'hFFC, len 2, addr_ready = 1 → 16'h1FFC, 16'h1FFD, 16'h1FFE on consecutive cycles; addr_last only on 16'h1FFE; err never asserts.
- Region 7, offset 12'h800, len 0 → single beat 16'hF800 with addr_last = 1; cmd_ready back 1 cycle after the handshake.
- Region 5, any offset/len → no addr_valid; err high exactly 1 cycle, the cycle after acceptance; busy high for that cycle.
- Region 2, offset 12'h500, len 3, addr_ready low for 3 cycles on beat 2 → 16'h2501 held stable across the stall; sequence 2500, 2501, 2502, 2503 completes.
- Region 0, offset 12'hFFE, len 3:
  - With REGION_ADDR_WRAP_EN → 0FFE, 0FFF, 0000, 0001, no err.
  - Without it → 0FFE, 0FFF (addr_last), then an err pulse.
- rst asserted during beat 2 of a region 3 burst → next cycle all outputs at reset values; a new command accepted cleanly after rst is released.
